// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared constants, state encoding and operand helper for the divider
package div_unit_pkg;
    localparam int DATA_W = 32;
    localparam int DOUBLE_W = 2 * DATA_W;
    localparam logic [5:0] DIV_STEPS = 6'd32;
    localparam logic DIV_READY = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP = 1'b0;
    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;
    // Two's-complement magnitude for signed negatives; 0x80000000 stays 0x80000000 and is read as unsigned
    function automatic logic [DATA_W-1:0] magnitude(input logic signed_div, input logic [DATA_W-1:0] x);
        return (signed_div && x[DATA_W-1]) ? -x : x;
    endfunction
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: EX-to-divider request/result handshake
interface div_unit_if;
    import div_unit_pkg::*;
    logic                signed_div_i;
    logic [DATA_W-1:0]   opdata1_i;
    logic [DATA_W-1:0]   opdata2_i;
    logic                start_i;
    logic                annul_i;
    logic [DOUBLE_W-1:0] result_o;
    logic                ready_o;
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit radix-2 restoring divider returning {remainder, quotient}
module div_unit
    import div_unit_pkg::*;
(
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    div_state_t          state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [64:0]         dreg_q, dreg_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                sdiv_q, sdiv_d;
    logic                sign1_q, sign1_d;
    logic                sign2_q, sign2_d;
    logic [DOUBLE_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;
    logic [32:0]         diff;
    logic [DATA_W-1:0]   quo, rem;

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

    // State and datapath registers; reset clears everything back to an idle, zeroed divider
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            dreg_q    <= '0;
            divisor_q <= '0;
            sdiv_q    <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dreg_q    <= dreg_d;
            divisor_q <= divisor_d;
            sdiv_q    <= sdiv_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state, one restoring subtract step per cycle, and final sign correction
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dreg_d    = dreg_q;
        divisor_d = divisor_q;
        sdiv_d    = sdiv_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        result_d  = result_q;
        ready_d   = ready_q;
        diff      = {1'b0, dreg_q[63:32]} - {1'b0, divisor_q};
        quo       = (sdiv_q && (sign1_q ^ sign2_q)) ? -dreg_q[31:0] : dreg_q[31:0];
        rem       = (sdiv_q && sign1_q) ? -dreg_q[64:33] : dreg_q[64:33];
        case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_NOT_READY;
                result_d = '0;
                if (bus.start_i == DIV_START && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d   = DIV_ON;
                        cnt_d     = '0;
                        dreg_d    = {32'b0, magnitude(bus.signed_div_i, bus.opdata1_i), 1'b0};
                        divisor_d = magnitude(bus.signed_div_i, bus.opdata2_i);
                        sdiv_d    = bus.signed_div_i;
                        sign1_d   = bus.opdata1_i[DATA_W-1];
                        sign2_d   = bus.opdata2_i[DATA_W-1];
                    end
                end
            end
            DIV_BYZERO: begin
                state_d  = bus.annul_i ? DIV_FREE : DIV_END;
                result_d = '0;
                ready_d  = bus.annul_i ? DIV_NOT_READY : DIV_READY;
            end
            DIV_ON: begin
                if (bus.annul_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_NOT_READY;
                end else if (cnt_q == DIV_STEPS) begin
                    state_d  = DIV_END;
                    result_d = {rem, quo};
                    ready_d  = DIV_READY;
                end else begin
                    dreg_d = diff[32] ? {dreg_q[63:0], 1'b0} : {diff[31:0], dreg_q[31:0], 1'b1};
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            DIV_END: begin
                if (bus.start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_NOT_READY;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for the restoring divider
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_fail = 0;

    div_unit_if bus();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic start_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
    endtask

    task automatic wait_ready(input string name, input int lat, input logic [63:0] exp);
        int cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.ready_o && cyc < 60);
        n_checks++;
        if (cyc !== lat) begin
            n_fail++;
            $display("FAIL %s edges_to_ready: got %0d want %0d", name, cyc, lat);
        end
        n_checks++;
        if (bus.result_o !== exp) begin
            n_fail++;
            $display("FAIL %s result: got %h want %h", name, bus.result_o, exp);
        end
    endtask

    task automatic release_div(input string name);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            n_fail++;
            $display("FAIL %s release: got ready=%b result=%h want ready=0 result=0", name, bus.ready_o, bus.result_o);
        end
    endtask

    task automatic run_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input logic [63:0] exp);
        start_div(s, a, b);
        wait_ready(name, lat, exp);
        release_div(name);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            n_fail++;
            $display("FAIL reset: got ready=%b result=%h want ready=0 result=0", bus.ready_o, bus.result_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned;
        run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, 34, 64'h00000002_0000000E);
        run_div("udiv_ffff_1", 1'b0, 32'hFFFFFFFF, 32'd1, 34, 64'h00000000_FFFFFFFF);
        run_div("udiv_neg_raw", 1'b0, 32'hFFFFFFF9, 32'd2, 34, 64'h00000001_7FFFFFFC);
    endtask

    task automatic test_signed;
        run_div("sdiv_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 34, 64'hFFFFFFFF_FFFFFFFD);
        run_div("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 34, 64'h00000001_FFFFFFFD);
        run_div("sdiv_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 64'h00000000_80000000);
        run_div("sdiv_m1_1", 1'b1, 32'hFFFFFFFF, 32'd1, 34, 64'h00000000_FFFFFFFF);
        run_div("sdiv_m20_m6", 1'b1, 32'hFFFFFFEC, 32'hFFFFFFFA, 34, 64'hFFFFFFFE_00000003);
    endtask

    task automatic test_div_by_zero;
        run_div("div_zero", 1'b0, 32'h12345678, 32'd0, 2, 64'h0);
        run_div("sdiv_zero", 1'b1, 32'hFFFFFFFF, 32'd0, 2, 64'h0);
    endtask

    task automatic test_operand_change;
        start_div(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        bus.opdata1_i = 32'd5;
        bus.opdata2_i = 32'd0;
        bus.signed_div_i = 1'b1;
        wait_ready("operand_change", 33, 64'h00000002_0000000E);
        release_div("operand_change");
    endtask

    task automatic test_annul;
        int highs = 0;
        start_div(1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            n_fail++;
            $display("FAIL annul_edge: got ready=%b result=%h want ready=0 result=0", bus.ready_o, bus.result_o);
        end
        @(negedge clk);
        bus.annul_i = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) highs++;
        end
        n_checks++;
        if (highs !== 0) begin
            n_fail++;
            $display("FAIL annul_no_ready: got %0d ready cycles want 0", highs);
        end
        run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 34, 64'h00000000_00000003);
    endtask

    task automatic test_annul_blocks_start;
        int highs = 0;
        @(negedge clk);
        bus.annul_i = 1'b1;
        start_div(1'b0, 32'd50, 32'd5);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) highs++;
        end
        n_checks++;
        if (highs !== 0) begin
            n_fail++;
            $display("FAIL annul_block: got %0d ready cycles want 0", highs);
        end
        @(negedge clk);
        bus.annul_i = 1'b0;
        wait_ready("annul_block_then_go", 34, 64'h00000000_0000000A);
        release_div("annul_block_then_go");
    endtask

    task automatic test_end_hold;
        start_div(1'b0, 32'd100, 32'd7);
        wait_ready("end_hold", 34, 64'h00000002_0000000E);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.annul_i = (i == 2);
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000002_0000000E) begin
                n_fail++;
                $display("FAIL end_hold[%0d]: got ready=%b result=%h want ready=1 result=000000020000000e", i, bus.ready_o, bus.result_o);
            end
        end
        bus.annul_i = 1'b0;
        release_div("end_hold");
    endtask

    task automatic test_reset_mid;
        start_div(1'b0, 32'd100, 32'd7);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got ready=%b result=%h want ready=0 result=0", bus.ready_o, bus.result_o);
        end
        @(negedge clk);
        rst = 1'b0;
        run_div("after_reset_21_4", 1'b0, 32'd21, 32'd4, 34, 64'h00000001_00000005);
    endtask

    initial begin
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        test_reset;
        test_unsigned;
        test_signed;
        test_div_by_zero;
        test_operand_change;
        test_annul;
        test_annul_blocks_start;
        test_end_hold;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider.
- Responder to the EX stage's divide request handshake. EX drives the operands and `start_i`; this block returns the 64-bit result {remainder, quotient} and `ready_o`.
- The result feeds EX's hi_o/lo_o/whilo_o path: HI = remainder, LO = quotient.
- EX stalls the pipeline while a divide is in flight.

Parameters:
- DATA_W, 32, operand width. Only 32 is supported; the parameter exists for documentation.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  divide request; level, held by EX until it has consumed the result
- annul_i  in  1  cancel the in-flight divide (flush or exception)
- result_o  out  64  {remainder[63:32], quotient[31:0]}
- ready_o  out  1  result valid

Behaviour:
- Reset (`rst`=1 at a clock edge): state = FREE, `ready_o`=0, `result_o`=0, counter = 0, dividend register = 0.
- States: FREE, BYZERO, ON, END. Encodings are 2'b00, 2'b01, 2'b10, 2'b11.
- FREE:
  - On `start_i`=1 and `annul_i`=0 with `opdata2_i`=0: go to BYZERO.
  - On `start_i`=1 and `annul_i`=0 with `opdata2_i`≠0: go to ON, counter = 0, latch operands.
  - Otherwise stay in FREE with `ready_o`=0 and `result_o`=0.
- Operand conditioning, done at latch time:
  - If `signed_div_i`=1 and the operand's bit 31 = 1, latch its two's-complement magnitude; otherwise latch the raw value.
  - Latch `signed_div_i`, `opdata1_i[31]` and `opdata2_i[31]` for the final sign fix.
  - 0x80000000 maps to magnitude 0x80000000, treated as unsigned.
- Dividend register, 65 bits: initialised to {32'b0, |dividend|, 1'b0}.
- ON iteration, once per cycle:
  - diff = {1'b0, dreg[63:32]} − {1'b0, |divisor|}, 33 bits.
  - If diff[32]=1: dreg = {dreg[63:0], 1'b0}.
  - Else: dreg = {diff[31:0], dreg[31:0], 1'b1}.
  - counter = counter + 1.
- Completion: when counter = 32, the next edge goes to END and registers the result.
  - quotient = dreg[31:0], negated if the divide is signed and the two latched sign bits differ.
  - remainder = dreg[64:33], negated if the divide is signed and the dividend sign bit is 1 (remainder takes the dividend's sign).
  - `ready_o`=1 on the same edge.
- BYZERO: the next edge goes to END with `result_o`=0 and `ready_o`=1. Divide by zero raises no exception.
- END:
  - `result_o` and `ready_o` hold while `start_i`=1.
  - When `start_i`=0, the next edge goes to FREE with `ready_o`=0 and `result_o`=0.
- Latency: with edge N being the first edge to sample `start_i` in FREE, `ready_o` is high after edge N+33 for a normal divide and after edge N+1 for divide by zero.
- `annul_i`=1:
  - In ON or BYZERO: the next edge goes to FREE, `ready_o` stays 0 and the partial result is discarded.
  - In FREE: blocks the start.
  - In END: ignored; exit from END is by `start_i`=0 only.
- Simultaneous `annul_i` and `start_i` in FREE: annul wins and the state stays FREE.
- Operand changes on the inputs during ON have no effect, because the operands are latched.
- Reset mid-operation has priority over everything and returns the block to FREE within one edge.
- Special case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This is wrap-around behaviour, not trapped.

Decomposition:
- Constants for defines.v:
  - `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (state encodings).
  - `DivResultReady` / `DivResultNotReady`.
  - `DivStart` / `DivStop`.
  - `DoubleRegBus`.
- Single module; no sub-module warranted. The subtract step is an inline combinational expression.
- EX-side additions are a separate change: `div_opdata1_o`, `div_opdata2_o`, `div_start_o`, `signed_div_o`, and a stall request.

Test Plan:
- Unsigned 100 / 7, `start_i` held: `ready_o`=1 after edge N+33, `result_o`=64'h00000002_0000000E.
- Signed −7 (0xFFFFFFF9) / 2: `result_o`=64'hFFFFFFFF_FFFFFFFD. Signed 7 / −2: 64'h00000001_FFFFFFFD.
- Divide by zero, 0x12345678 / 0: `ready_o`=1 after edge N+1, `result_o`=0. Signed 0x80000000 / 0xFFFFFFFF: 64'h00000000_80000000.
- Unsigned 0xFFFFFFFF / 1 gives 64'h00000000_FFFFFFFF. Signed 0xFFFFFFFF / 1 gives 64'h00000000_FFFFFFFF (quotient −1).
- `annul_i` pulse at edge N+10: `ready_o` never rises, state is FREE at N+11. A new start of 9/3 then yields 64'h00000000_00000003 after 33 more edges.
- Hold `start_i` 5 cycles in END: `result_o` stays stable. Drop `start_i`: after the next edge `ready_o`=0 and `result_o`=0. Assert `rst` during ON: FREE and zeroed outputs after one edge.
